result_streamer: RTL and testbench
==================================

# result_streamer

Reads the 4x4 result matrix out of the shared matrix memory after the MAC controller signals completion and streams it to the UART transmitter as a framed byte sequence: header, 16 data bytes in row-major order, then an 8-bit checksum. It owns the memory read port only while streaming and requests it through `mem_req`. It drives the transmitter through a level handshake that is safe across the clk/bclk boundary.

## Interface
Parameters:
- `HEADER`, 8'hA5: first byte of every frame.
- `RESULT_SEL`, 2'd2: `matrix_select` value that addresses the result matrix.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse from the MAC controller `done`; starts a frame.
- `read_data`  in  8  memory read data, valid one `clk` after address is presented.
- `tx_busy`  in  1  transmitter busy level (bclk domain), double-flopped internally.
- `mem_req`  out  1  high while the block owns the memory port; top-level mux select.
- `matrix_select`  out  2  fixed at `RESULT_SEL` while `mem_req` = 1, else 0.
- `row`  out  2  result row being read.
- `col`  out  2  result column being read.
- `tx_load`  out  1  level request to the transmitter; held until acknowledged.
- `tx_data`  out  8  byte to send; stable whenever `tx_load` = 1.
- `busy`  out  1  high from accepted `start` until frame end.
- `frame_done`  out  1  one-cycle pulse after the checksum byte is acknowledged.

## Operation
- States: IDLE, HDR, ADDR, FETCH, SEND, WAIT_ACK, WAIT_IDLE, CSUM, FINISH.
- IDLE: all outputs 0. `start` = 1 moves to HDR, clears index (row=0, col=0) and checksum, and sets `busy`.
- HDR: load `tx_data` = `HEADER`, then go to SEND. The header is not included in the checksum.
- ADDR: assert `mem_req`, drive `row`/`col`, go to FETCH.
- FETCH: latch `read_data` into `tx_data`, add it to the checksum (mod 256), go to SEND.
- SEND: assert `tx_load`, go to WAIT_ACK.
- WAIT_ACK: hold `tx_load` and `tx_data` until synchronized `tx_busy` = 1, then drop `tx_load` and go to WAIT_IDLE.
- WAIT_IDLE: wait for synchronized `tx_busy` = 0, then choose the next state:
  - after the header: go to ADDR;
  - after a data byte with index < 15: advance col, wrapping col 3 to 0 and row+1, then go to ADDR;
  - after data byte 15: go to CSUM;
  - after the checksum byte: go to FINISH.
- CSUM: `tx_data` = checksum, go to SEND.
- FINISH: pulse `frame_done`, clear `busy` and `mem_req`, return to IDLE.
- `mem_req` is held high from the first ADDR through FINISH. The memory must not be written by other masters during a frame.
- `start` while `busy` = 1 is ignored. There is no queueing.
- Checksum is the 8-bit sum of the 16 data bytes, with carries discarded.

## Timing
- Reset (asynchronous): state IDLE; `tx_load`, `tx_data`, `mem_req`, `matrix_select`, `row`, `col`, `busy`, `frame_done` all 0; checksum 0; synchronizer flops 0.
- `start` at edge k: `busy` = 1 at k+1, `tx_load` = 1 at k+2 carrying `HEADER`.
- Memory read: address valid in ADDR (cycle a), `read_data` sampled at the end of FETCH (cycle a+1), `tx_load` rises at a+2.
- `tx_busy` synchronizer latency is 2 `clk`. `tx_load` falls 3 cycles after `tx_busy` rises.
- The next `tx_load` rises no earlier than 3 cycles after `tx_busy` falls, plus an extra ADDR/FETCH cost of 2 cycles for data bytes.
- Frame length is 18 bytes. Throughput is bounded by the transmitter, not by this block.
- Reset mid-frame aborts immediately with no `frame_done`. The next `start` begins a full new frame.

## Test plan
- Result matrix preloaded with bytes 8'h01..8'h10, `start` pulse, transmitter model acks after 5 clk and stays busy 20 clk -> bytes sent are A5, 01..10, 88 in order; `frame_done` pulses once; `busy` is low afterward.
- Result matrix all 8'hFF -> checksum byte 8'hF0 (wrap); `row`/`col` visit (0,0)..(3,3) row-major; `matrix_select` = 2 throughout.
- `tx_busy` withheld for 200 clk after the header `tx_load` -> `tx_load` and `tx_data` = A5 are held stable for all 200 clk; no memory read occurs.
- Second `start` pulse during byte 7 -> ignored; frame completes with 18 bytes and a single `frame_done`.
- `reset` asserted during byte 10 -> all outputs 0 asynchronously; a later `start` resends from `HEADER` with a correct checksum.
- `start` while `tx_busy` is stuck high from a previous transfer -> HDR waits in WAIT_IDLE-equivalent handling, and the header `tx_load` is acknowledged only after a fresh busy rise.

Source files
------------

// File: rtl/result_streamer.sv
// result_streamer: after a MAC run, reads the 4x4 result matrix and sends it
// to the UART transmitter as one frame: HEADER, 16 data bytes in row-major
// order, then the 8-bit sum of the data bytes.
module result_streamer #(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter logic [1:0] RESULT_SEL = 2'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] read_data,
  input  logic       tx_busy,
  output logic       mem_req,
  output logic [1:0] matrix_select,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       tx_load,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       frame_done,
  output logic [3:0] dbg_state
);

  // Transmitter handshake (level based, safe across clk/bclk):
  //   tx_load rises with tx_data already stable and both stay unchanged until
  //   the synchronized tx_busy is seen high; tx_load then drops. A new byte is
  //   offered only once the synchronized tx_busy has been seen low again, so
  //   every byte is paired with exactly one busy pulse.

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_HDR       = 4'd1;
  localparam logic [3:0] S_ADDR      = 4'd2;
  localparam logic [3:0] S_FETCH     = 4'd3;
  localparam logic [3:0] S_SEND      = 4'd4;
  localparam logic [3:0] S_WAIT_ACK  = 4'd5;
  localparam logic [3:0] S_WAIT_IDLE = 4'd6;
  localparam logic [3:0] S_CSUM      = 4'd7;
  localparam logic [3:0] S_FINISH    = 4'd8;

  // Which kind of byte is currently in flight.
  localparam logic [1:0] PH_HDR  = 2'd0;
  localparam logic [1:0] PH_DATA = 2'd1;
  localparam logic [1:0] PH_CSUM = 2'd2;

  logic [3:0] state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_load_q, tx_load_d;
  logic       mem_req_q, mem_req_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic       busy_s1_q, busy_s2_q;
  logic       tx_busy_sync;

  // Two-flop synchronizer for the transmitter busy level (bclk domain).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
    end else begin
      busy_s1_q <= tx_busy;
      busy_s2_q <= busy_s1_q;
    end
  end

  assign tx_busy_sync = busy_s2_q;

  // Next-state logic; outputs are registered and set on entry to a state.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    row_d        = row_q;
    col_d        = col_q;
    csum_d       = csum_q;
    tx_data_d    = tx_data_q;
    tx_load_d    = tx_load_q;
    mem_req_d    = mem_req_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          row_d   = 2'd0;
          col_d   = 2'd0;
          csum_d  = 8'd0;
          busy_d  = 1'b1;
        end
      end
      S_HDR: begin
        // A transmitter still busy from an earlier transfer must go idle
        // first, otherwise its stale busy level would look like an ack.
        if (!tx_busy_sync) begin
          tx_data_d = HEADER;
          tx_load_d = 1'b1;
          phase_d   = PH_HDR;
          state_d   = S_SEND;
        end
      end
      S_ADDR: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        tx_data_d = read_data;
        csum_d    = csum_q + read_data;
        tx_load_d = 1'b1;
        phase_d   = PH_DATA;
        state_d   = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy_sync) begin
          tx_load_d = 1'b0;
          state_d   = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (!tx_busy_sync) begin
          case (phase_q)
            PH_HDR: begin
              mem_req_d = 1'b1;
              state_d   = S_ADDR;
            end
            PH_DATA: begin
              if (row_q == 2'd3 && col_q == 2'd3) begin
                state_d = S_CSUM;
              end else begin
                if (col_q == 2'd3) begin
                  col_d = 2'd0;
                  row_d = row_q + 2'd1;
                end else begin
                  col_d = col_q + 2'd1;
                end
                state_d = S_ADDR;
              end
            end
            default: begin
              frame_done_d = 1'b1;
              state_d      = S_FINISH;
            end
          endcase
        end
      end
      S_CSUM: begin
        tx_data_d = csum_q;
        tx_load_d = 1'b1;
        phase_d   = PH_CSUM;
        state_d   = S_SEND;
      end
      S_FINISH: begin
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        row_d     = 2'd0;
        col_d     = 2'd0;
        tx_data_d = 8'd0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_HDR;
      row_q        <= 2'd0;
      col_q        <= 2'd0;
      csum_q       <= 8'd0;
      tx_data_q    <= 8'd0;
      tx_load_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      row_q        <= row_d;
      col_q        <= col_d;
      csum_q       <= csum_d;
      tx_data_q    <= tx_data_d;
      tx_load_q    <= tx_load_d;
      mem_req_q    <= mem_req_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign matrix_select = mem_req_q ? RESULT_SEL : 2'd0;
  assign row           = row_q;
  assign col           = col_q;
  assign tx_load       = tx_load_q;
  assign tx_data       = tx_data_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer: synchronous memory model, transmitter model that
// acks each tx_load with a busy pulse, and a byte scoreboard built from the
// frame definition (header, row-major data, sum mod 256).
module tb_result_streamer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic [7:0] read_data;
  logic       tx_busy;
  logic       model_busy;
  logic       stuck_busy;
  logic       mem_req;
  logic [1:0] matrix_select;
  logic [1:0] row;
  logic [1:0] col;
  logic       tx_load;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_done;
  logic [3:0] dbg_state;

  assign tx_busy = model_busy | stuck_busy;

  result_streamer #(.HEADER(8'hA5), .RESULT_SEL(2'd2)) dut (
    .clk(clk), .reset(reset), .start(start), .read_data(read_data),
    .tx_busy(tx_busy), .mem_req(mem_req), .matrix_select(matrix_select),
    .row(row), .col(col), .tx_load(tx_load), .tx_data(tx_data),
    .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  int load_n = 0;
  int done_cnt = 0;
  int busy_rise_cyc = 0;
  logic prev_load = 1'b0;
  logic [7:0] held_data = 8'd0;
  int ack_delay = 5;
  int busy_len = 20;
  int first_delay = 0;
  bit rand_delays = 1'b0;
  bit tx_rst = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- memory model: one-cycle synchronous read ----------------
  initial begin
    logic [3:0] a;
    logic       r;
    read_data = 8'd0;
    forever begin
      @(posedge clk);
      a = {row, col};
      r = mem_req;
      #1;
      read_data = r ? mem[a] : 8'($urandom);
    end
  end

  // ---------------- transmitter model + scoreboard ----------------
  initial begin
    int ph;
    int cnt;
    logic [7:0] e;
    ph = 0;
    cnt = 0;
    model_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_rst) begin
        ph = 0;
        cnt = 0;
        model_busy = 1'b0;
        tx_rst = 1'b0;
      end else begin
        case (ph)
          0: if (tx_load) begin
            if (load_n == 1 && first_delay > 0) begin
              cnt = first_delay;
              first_delay = 0;
            end else begin
              cnt = ack_delay;
            end
            ph = 1;
          end
          1: begin
            cnt--;
            if (cnt <= 0) begin
              check("byte_avail", 32'(exp_q.size() != 0), 1);
              check("load_at_ack", tx_load, 1);
              if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("byte", tx_data, e);
              end
              model_busy = 1'b1;
              busy_rise_cyc = cyc;
              cnt = busy_len;
              ph = 2;
            end
          end
          2: begin
            cnt--;
            if (cnt <= 0) begin
              model_busy = 1'b0;
              ph = 3;
            end
          end
          default: if (!tx_load) begin
            ph = 0;
            if (rand_delays) begin
              ack_delay = $urandom_range(1, 8);
              busy_len  = $urandom_range(3, 25);
            end
          end
        endcase
      end
    end
  end

  // ---------------- protocol monitor (samples on falling edge) ----------------
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_load = 1'b0;
    end else begin
      if (tx_load && !prev_load) begin
        load_n++;
        if (load_n == 1) begin
          check("hdr_nomem", mem_req, 0);
        end else if (load_n <= 17) begin
          check("rowcol", {row, col}, load_n - 2);
          check("msel", matrix_select, 2);
          check("memreq_data", mem_req, 1);
        end else begin
          check("memreq_csum", mem_req, 1);
        end
      end
      if (tx_load && prev_load) begin
        check("tx_hold", tx_data, held_data);
        if (load_n == 1) check("hold_nomem", mem_req, 0);
      end
      if (!tx_load && prev_load) check("ack_lat", cyc - busy_rise_cyc, 3);
      if (frame_done) done_cnt++;
      prev_load = tx_load;
      held_data = tx_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle();
    check("idle_tx_load", tx_load, 0);
    check("idle_tx_data", tx_data, 0);
    check("idle_mem_req", mem_req, 0);
    check("idle_msel", matrix_select, 0);
    check("idle_row", row, 0);
    check("idle_col", col, 0);
    check("idle_busy", busy, 0);
    check("idle_frame_done", frame_done, 0);
  endtask

  task automatic build_exp();
    int s;
    s = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(mem[i]);
      s += int'(mem[i]);
    end
    exp_q.push_back(8'(s % 256));
  endtask

  task automatic start_frame(input bit hdr_now);
    build_exp();
    load_n = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("load_pre", tx_load, 0);
    if (hdr_now) begin
      @(negedge clk);
      check("hdr_load", tx_load, 1);
      check("hdr_data", tx_data, 8'hA5);
    end
  endtask

  task automatic do_abort();
    #2;
    reset = 1'b1;
    tx_rst = 1'b1;
    #1;
    check_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    load_n = 0;
    done_cnt = 0;
    repeat (5) @(negedge clk);
    check("no_done_abort", done_cnt, 0);
    check("abort_idle_busy", busy, 0);
  endtask

  task automatic wait_frame(input int inject_at, input int abort_at);
    bit inj;
    bit fin;
    int n;
    inj = 1'b0;
    fin = 1'b0;
    n = 0;
    while (!fin && n < 5000) begin
      @(negedge clk);
      n++;
      if (start) start = 1'b0;
      if (frame_done) begin
        fin = 1'b1;
      end else if (inject_at > 0 && load_n == inject_at && !inj) begin
        start = 1'b1;
        inj = 1'b1;
      end else if (abort_at > 0 && load_n == abort_at) begin
        do_abort();
        return;
      end
    end
    start = 1'b0;
    check("frame_timeout", fin, 1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("bytes_left", exp_q.size(), 0);
    check("load_count", load_n, 18);
    check("busy_after", busy, 0);
    check("memreq_after", mem_req, 0);
    check("msel_after", matrix_select, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    stuck_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Counting pattern 01..10: checksum 0x88.
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    start_frame(1'b1);
    wait_frame(0, 0);

    // All 0xFF: checksum wraps to 0xF0.
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    start_frame(1'b1);
    wait_frame(0, 0);

    // Header ack withheld for 200 cycles.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    first_delay = 200;
    start_frame(1'b1);
    wait_frame(0, 0);

    // Random data and transmitter timing; second start during data byte 7.
    rand_delays = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      start_frame(1'b1);
      wait_frame((r == 0) ? 9 : 0, 0);
    end

    // Reset during data byte 10, then a full new frame.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    start_frame(1'b1);
    wait_frame(0, 12);
    start_frame(1'b1);
    wait_frame(0, 0);

    // Start while tx_busy is stuck high from an earlier transfer.
    rand_delays = 1'b0;
    ack_delay = 5;
    busy_len = 20;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    stuck_busy = 1'b1;
    repeat (5) @(negedge clk);
    start_frame(1'b0);
    repeat (30) @(negedge clk);
    check("stuck_no_load", tx_load, 0);
    check("stuck_busy_hi", busy, 1);
    stuck_busy = 1'b0;
    wait_frame(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
